multicycle_control: RTL and testbench
=====================================

// Module: multicycle_control
// PURPOSE
//  Multi-cycle control FSM for the 3-bit-opcode/4-bit-funct core ISA (R-type, xori, beq, bgt, sw, lw, j).
//  Sequences fetch/decode/execute/memory/writeback over a shared single-port memory with a ready handshake.
//  Sits between the instruction register (opcode/funct in) and the datapath muxes, ALU, register file and PC.
//  Adds a run/idle gate, memory wait timeout, illegal-opcode detection and instruction-retire pulse.
// PARAMETERS
//  OPCODE_W    3   opcode field width; opcodes above 3'b110 (zero-extended) are illegal
//  FUNCT_W     4   funct field width
//  MEM_TIMEOUT 15  max wait cycles per memory access before mem_err (1..2**TMR_W-1)
//  TMR_W       4   width of the wait counter
// PORTS
//  clk         in   1         rising-edge clock
//  rst_n       in   1         asynchronous active-low reset
//  run         in   1         1: execute instructions; 0: stop at next instruction boundary
//  opcode      in   OPCODE_W  IR opcode field (stable from DECODE onward)
//  funct       in   FUNCT_W   IR funct field
//  alu_zero    in   1         ALU result == 0 (beq condition)
//  alu_gt      in   1         rs > rt (bgt condition)
//  mem_ready   in   1         memory completes the current access this cycle
//  mem_read    out  1         memory read request (fetch or lw)
//  mem_write   out  1         memory write request (sw)
//  iord        out  1         0: address = PC; 1: address = ALUOut
//  ir_write    out  1         load IR
//  pc_write    out  1         update PC
//  pc_src      out  2         00 PC+1, 01 branch target, 10 jump target
//  reg_dst     out  1         1: rd, 0: rt
//  reg_write   out  1         register-file write enable
//  mem_to_reg  out  1         1: write memory data, 0: ALUOut
//  alu_src_b   out  2         00 reg B, 01 constant 1, 10 immediate
//  alu_op      out  2         00 add, 01 sub/compare, 10 funct-decoded, 11 xor
//  sign_zero   out  1         1: sign-extend immediate, 0: zero-extend
//  instr_done  out  1         1-cycle pulse in final state of every retired instruction
//  illegal_op  out  1         sticky: illegal opcode decoded
//  mem_err     out  1         sticky: memory access exceeded MEM_TIMEOUT
//  busy        out  1         state != IDLE
// BEHAVIOUR
//  - Reset (async): state IDLE, wait counter 0, illegal_op/mem_err 0; all outputs 0 while rst_n=0 and in IDLE.
//  - All outputs except ir_write/pc_write/state advance in memory states are Moore (decoded from state only).
//  - IDLE: -> FETCH when run=1.
//  - FETCH: mem_read=1, iord=0, alu_src_b=01, alu_op=00. Hold until mem_ready=1; that cycle ir_write=1,
//    pc_write=1, pc_src=00, -> DECODE. Same-cycle gating: ir_write/pc_write = (state==FETCH) & mem_ready.
//  - DECODE (1 cycle): alu_src_b=10, sign_zero=1 (branch target precompute). Dispatch on opcode:
//    000->EXEC_R, 001->EXEC_I, 010/011->BRANCH, 100/101->ADDR, 110->JUMP, other->FETCH w/ illegal_op set, instr_done=0.
//  - EXEC_R: alu_op=10; alu_src_b=10 if funct==SHL or SHR (shift by immediate) else 00 -> WB_R.
//  - EXEC_I: alu_op=11, alu_src_b=10, sign_zero=0 -> WB_I.
//  - ADDR: alu_op=00, alu_src_b=10, sign_zero=1 -> MEM_RD (lw) / MEM_WR (sw).
//  - MEM_RD: mem_read=1, iord=1; on mem_ready -> WB_MEM.  MEM_WR: mem_write=1, iord=1; on mem_ready ->
//    FETCH/IDLE with instr_done=1.
//  - WB_R: reg_write=1, reg_dst=1.  WB_I: reg_write=1, reg_dst=0.  WB_MEM: reg_write=1, reg_dst=0,
//    mem_to_reg=1. All assert instr_done and exit.
//  - BRANCH: alu_op=01, alu_src_b=00, pc_src=01; pc_write = opcode==010 ? alu_zero : alu_gt; instr_done=1; exit.
//  - JUMP: pc_write=1, pc_src=10, instr_done=1; exit.
//  - Exit = FETCH if run=1 else IDLE; run sampled only at instruction end (mid-instruction run=0 ignored).
//  - Wait counter: cleared on entering FETCH/MEM_RD/MEM_WR and on mem_ready; increments each cycle the state
//    holds with mem_ready=0. Counter reaching MEM_TIMEOUT: mem_err set, request dropped, -> IDLE; counter saturates.
//  - mem_err set blocks IDLE->FETCH until reset; illegal_op does not block execution.
//  - Cycles (mem_ready always 1): R/xori 4, beq/bgt 3, j 3, sw 4, lw 5; each wait cycle adds 1.
//  - Reset asserted mid-instruction: immediate IDLE, no partial writes (reg_write/mem_write drop async).
// STRUCTURE
//  - ctrl_pkg: state_t enum (IDLE,FETCH,DECODE,EXEC_R,EXEC_I,ADDR,MEM_RD,MEM_WR,WB_R,WB_I,WB_MEM,BRANCH,JUMP),
//    opcode constants OP_R..OP_J, ALUOP_* and PCSRC_*/SRCB_* encodings, FUNCT_SHL=4'h3, FUNCT_SHR=4'h4.
//  - Sub-module mem_wait_timer (TMR_W, MEM_TIMEOUT): clear/count/timeout; FSM and output decode in this file.
// TESTING
//  - Reset/idle: rst_n=0 then 1, run=0 for 5 cycles -> busy=0, all outputs 0, no mem_read.
//  - R-type add, mem_ready=1: run=1, opcode=000 funct=0 -> FETCH,DECODE,EXEC_R,WB_R; reg_write=1 reg_dst=1
//    in cycle 4, instr_done pulse once; funct=3 -> alu_src_b=10 in EXEC_R.
//  - lw with 3 wait cycles in MEM_RD: opcode=101 -> mem_read,iord=1 held 4 cycles; WB_MEM mem_to_reg=1; 8 cycles total.
//  - beq taken/not: opcode=010 alu_zero=1 -> pc_write=1 pc_src=01; alu_zero=0 -> pc_write=0; bgt uses alu_gt only.
//  - Timeout: MEM_TIMEOUT=15, mem_ready=0 in FETCH -> mem_err=1 after 15 wait cycles, IDLE, stays IDLE with run=1.
//  - Illegal+run drop: opcode=111 -> illegal_op=1, next FETCH, no instr_done; run=0 during lw -> lw completes, IDLE.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared definitions for the multi-cycle control unit.
//   state_t       : FSM state encoding
//   OP_*          : 3-bit opcode values of the core ISA
//   ALUOP_*       : ALU operation select (add / sub-compare / funct / xor)
//   PCSRC_*       : PC source mux select
//   SRCB_*        : ALU B-operand mux select
//   FUNCT_SHL/SHR : R-type funct codes that take the shift amount from the immediate
//   is_mem_state  : true in states that hold a memory request open
package ctrl_pkg;

  typedef enum logic [3:0] {
    IDLE,
    FETCH,
    DECODE,
    EXEC_R,
    EXEC_I,
    ADDR,
    MEM_RD,
    MEM_WR,
    WB_R,
    WB_I,
    WB_MEM,
    BRANCH,
    JUMP
  } state_t;

  localparam logic [2:0] OP_R    = 3'b000;
  localparam logic [2:0] OP_XORI = 3'b001;
  localparam logic [2:0] OP_BEQ  = 3'b010;
  localparam logic [2:0] OP_BGT  = 3'b011;
  localparam logic [2:0] OP_SW   = 3'b100;
  localparam logic [2:0] OP_LW   = 3'b101;
  localparam logic [2:0] OP_J    = 3'b110;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_XOR   = 2'b11;

  localparam logic [1:0] PCSRC_PC1 = 2'b00;
  localparam logic [1:0] PCSRC_BR  = 2'b01;
  localparam logic [1:0] PCSRC_JMP = 2'b10;

  localparam logic [1:0] SRCB_REG = 2'b00;
  localparam logic [1:0] SRCB_ONE = 2'b01;
  localparam logic [1:0] SRCB_IMM = 2'b10;

  localparam logic [3:0] FUNCT_SHL = 4'h3;
  localparam logic [3:0] FUNCT_SHR = 4'h4;

  function automatic logic is_mem_state(input state_t s);
    return (s == FETCH) || (s == MEM_RD) || (s == MEM_WR);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Memory wait-cycle counter.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : force the count to zero (new access or access completed)
//   inc        : a wait cycle is in progress (access pending, memory not ready)
//   timeout    : this wait cycle is the MEM_TIMEOUT-th one of the access
module mem_wait_timer #(
  parameter int TMR_W       = 4,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic inc,
  output logic timeout
);

  logic [TMR_W-1:0] cnt;

  // Flag on the cycle that would bring the count to MEM_TIMEOUT, so the
  // access is abandoned after exactly MEM_TIMEOUT wait cycles.
  assign timeout = inc && (cnt == TMR_W'(MEM_TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (inc && (cnt != TMR_W'(MEM_TIMEOUT))) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle control FSM for the 3-bit-opcode core ISA.
// Sequences fetch/decode/execute/memory/writeback over a single-port memory
// with a ready handshake, and drives the datapath mux selects and enables.
//   inputs : clk, rst_n (async, active-low), run, opcode, funct,
//            alu_zero, alu_gt (branch conditions), mem_ready
//   outputs: mem_read, mem_write, iord, ir_write, pc_write, pc_src,
//            reg_dst, reg_write, mem_to_reg, alu_src_b, alu_op, sign_zero,
//            instr_done (retire pulse), illegal_op, mem_err (sticky), busy
module multicycle_control
  import ctrl_pkg::*;
#(
  parameter int OPCODE_W    = 3,
  parameter int FUNCT_W     = 4,
  parameter int MEM_TIMEOUT = 15,
  parameter int TMR_W       = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                run,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [FUNCT_W-1:0]  funct,
  input  logic                alu_zero,
  input  logic                alu_gt,
  input  logic                mem_ready,
  output logic                mem_read,
  output logic                mem_write,
  output logic                iord,
  output logic                ir_write,
  output logic                pc_write,
  output logic [1:0]          pc_src,
  output logic                reg_dst,
  output logic                reg_write,
  output logic                mem_to_reg,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          alu_op,
  output logic                sign_zero,
  output logic                instr_done,
  output logic                illegal_op,
  output logic                mem_err,
  output logic                busy
);

  state_t state, state_next;
  logic   timeout;
  logic   tmr_clear;
  logic   tmr_inc;
  logic   set_illegal;
  state_t exit_state;

  // Instruction boundary: continue only while run is held high.
  assign exit_state = run ? FETCH : IDLE;
  assign busy       = (state != IDLE);

  assign tmr_inc   = is_mem_state(state) && !mem_ready;
  assign tmr_clear = mem_ready || ((state_next != state) && is_mem_state(state_next));

  mem_wait_timer #(
    .TMR_W      (TMR_W),
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (tmr_clear),
    .inc    (tmr_inc),
    .timeout(timeout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      illegal_op <= 1'b0;
      mem_err    <= 1'b0;
    end else begin
      state <= state_next;
      if (set_illegal) illegal_op <= 1'b1;
      if (timeout)     mem_err    <= 1'b1;
    end
  end

  always_comb begin
    state_next  = state;
    set_illegal = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    iord        = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    pc_src      = PCSRC_PC1;
    reg_dst     = 1'b0;
    reg_write   = 1'b0;
    mem_to_reg  = 1'b0;
    alu_src_b   = SRCB_REG;
    alu_op      = ALUOP_ADD;
    sign_zero   = 1'b0;
    instr_done  = 1'b0;

    case (state)
      IDLE: begin
        // A recorded memory error parks the unit until reset.
        if (run && !mem_err) state_next = FETCH;
      end

      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_ONE;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready)    state_next = DECODE;
        else if (timeout) state_next = IDLE;
      end

      DECODE: begin
        // ALU precomputes the branch target while the opcode is decoded.
        alu_src_b = SRCB_IMM;
        sign_zero = 1'b1;
        if (opcode == OPCODE_W'(OP_R))         state_next = EXEC_R;
        else if (opcode == OPCODE_W'(OP_XORI)) state_next = EXEC_I;
        else if (opcode == OPCODE_W'(OP_BEQ) ||
                 opcode == OPCODE_W'(OP_BGT))  state_next = BRANCH;
        else if (opcode == OPCODE_W'(OP_SW) ||
                 opcode == OPCODE_W'(OP_LW))   state_next = ADDR;
        else if (opcode == OPCODE_W'(OP_J))    state_next = JUMP;
        else begin
          set_illegal = 1'b1;
          state_next  = FETCH;
        end
      end

      EXEC_R: begin
        alu_op = ALUOP_FUNCT;
        if (funct == FUNCT_W'(FUNCT_SHL) || funct == FUNCT_W'(FUNCT_SHR))
          alu_src_b = SRCB_IMM;
        state_next = WB_R;
      end

      EXEC_I: begin
        alu_op     = ALUOP_XOR;
        alu_src_b  = SRCB_IMM;
        state_next = WB_I;
      end

      ADDR: begin
        alu_src_b  = SRCB_IMM;
        sign_zero  = 1'b1;
        state_next = (opcode == OPCODE_W'(OP_LW)) ? MEM_RD : MEM_WR;
      end

      MEM_RD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        if (mem_ready)    state_next = WB_MEM;
        else if (timeout) state_next = IDLE;
      end

      MEM_WR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        if (mem_ready) begin
          instr_done = 1'b1;
          state_next = exit_state;
        end else if (timeout) begin
          state_next = IDLE;
        end
      end

      WB_R: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
        state_next = exit_state;
      end

      WB_I: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_next = exit_state;
      end

      WB_MEM: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
        state_next = exit_state;
      end

      BRANCH: begin
        alu_op     = ALUOP_SUB;
        pc_src     = PCSRC_BR;
        pc_write   = (opcode == OPCODE_W'(OP_BEQ)) ? alu_zero : alu_gt;
        instr_done = 1'b1;
        state_next = exit_state;
      end

      JUMP: begin
        pc_write   = 1'b1;
        pc_src     = PCSRC_JMP;
        instr_done = 1'b1;
        state_next = exit_state;
      end

      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control. Control outputs are packed into one
// 16-bit word and compared against hand-computed per-state values.
// Word layout: [15]mem_read [14]mem_write [13]iord [12]ir_write [11]pc_write
//   [10:9]pc_src [8]reg_dst [7]reg_write [6]mem_to_reg [5:4]alu_src_b
//   [3:2]alu_op [1]sign_zero [0]instr_done
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       run;
  logic [2:0] opcode;
  logic [3:0] funct;
  logic       alu_zero, alu_gt, mem_ready;
  logic       mem_read, mem_write, iord, ir_write, pc_write;
  logic [1:0] pc_src, alu_src_b, alu_op;
  logic       reg_dst, reg_write, mem_to_reg, sign_zero, instr_done;
  logic       illegal_op, mem_err, busy;
  logic [15:0] ctl;

  int compared   = 0;
  int mismatched = 0;

  localparam logic [15:0] C_IDLE    = 16'h0000;
  localparam logic [15:0] C_FWAIT   = 16'h8010;
  localparam logic [15:0] C_FRDY    = 16'h9810;
  localparam logic [15:0] C_DECODE  = 16'h0022;
  localparam logic [15:0] C_EXR     = 16'h0008;
  localparam logic [15:0] C_EXR_SH  = 16'h0028;
  localparam logic [15:0] C_EXI     = 16'h002C;
  localparam logic [15:0] C_ADDR    = 16'h0022;
  localparam logic [15:0] C_MEMRD   = 16'hA000;
  localparam logic [15:0] C_MEMWR_R = 16'h6001;
  localparam logic [15:0] C_WBR     = 16'h0181;
  localparam logic [15:0] C_WBI     = 16'h0081;
  localparam logic [15:0] C_WBMEM   = 16'h00C1;
  localparam logic [15:0] C_BR_T    = 16'h0A05;
  localparam logic [15:0] C_BR_N    = 16'h0205;
  localparam logic [15:0] C_JUMP    = 16'h0C01;

  assign ctl = {mem_read, mem_write, iord, ir_write, pc_write, pc_src, reg_dst,
                reg_write, mem_to_reg, alu_src_b, alu_op, sign_zero, instr_done};

  multicycle_control #(
    .OPCODE_W(3), .FUNCT_W(4), .MEM_TIMEOUT(15), .TMR_W(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .funct(funct),
    .alu_zero(alu_zero), .alu_gt(alu_gt), .mem_ready(mem_ready),
    .mem_read(mem_read), .mem_write(mem_write), .iord(iord),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .reg_dst(reg_dst), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .sign_zero(sign_zero),
    .instr_done(instr_done), .illegal_op(illegal_op), .mem_err(mem_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Let combinational outputs settle, then check control word and busy.
  task automatic st(input string tag, input logic [15:0] exp_ctl, input logic exp_busy);
    #1;
    chk({tag, ".ctl"}, ctl, exp_ctl);
    chk({tag, ".busy"}, {15'd0, busy}, {15'd0, exp_busy});
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; run = 1'b0; opcode = 3'b000; funct = 4'h0;
    alu_zero = 1'b0; alu_gt = 1'b0; mem_ready = 1'b1;

    st("reset", C_IDLE, 1'b0);
    chk("reset.flags", {14'd0, illegal_op, mem_err}, 16'd0);
    tick; tick;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick;
      st("idle", C_IDLE, 1'b0);
    end

    // R-type add, then shift-by-immediate
    run = 1'b1;
    st("r.idle", C_IDLE, 1'b0);
    tick; st("r.fetch", C_FRDY, 1'b1);
    tick; st("r.decode", C_DECODE, 1'b1);
    tick; st("r.exec", C_EXR, 1'b1);
    tick; st("r.wb", C_WBR, 1'b1);
    funct = 4'h3;
    tick; st("shl.fetch", C_FRDY, 1'b1);
    tick; st("shl.decode", C_DECODE, 1'b1);
    tick; st("shl.exec", C_EXR_SH, 1'b1);
    tick; st("shl.wb", C_WBR, 1'b1);

    // lw with 3 wait cycles in MEM_RD
    funct = 4'h0; opcode = 3'b101;
    tick; st("lw.fetch", C_FRDY, 1'b1);
    tick; st("lw.decode", C_DECODE, 1'b1);
    tick; st("lw.addr", C_ADDR, 1'b1);
    mem_ready = 1'b0;
    tick; st("lw.memrd0", C_MEMRD, 1'b1);
    tick; st("lw.memrd1", C_MEMRD, 1'b1);
    tick; st("lw.memrd2", C_MEMRD, 1'b1);
    tick; mem_ready = 1'b1; st("lw.memrd3", C_MEMRD, 1'b1);
    tick; st("lw.wbmem", C_WBMEM, 1'b1);

    // sw
    opcode = 3'b100;
    tick; st("sw.fetch", C_FRDY, 1'b1);
    tick; st("sw.decode", C_DECODE, 1'b1);
    tick; st("sw.addr", C_ADDR, 1'b1);
    tick; st("sw.memwr", C_MEMWR_R, 1'b1);

    // xori
    opcode = 3'b001;
    tick; st("xori.fetch", C_FRDY, 1'b1);
    tick; st("xori.decode", C_DECODE, 1'b1);
    tick; st("xori.exec", C_EXI, 1'b1);
    tick; st("xori.wb", C_WBI, 1'b1);

    // beq taken / not taken, bgt taken / not taken (other flag set opposite)
    opcode = 3'b010; alu_zero = 1'b1; alu_gt = 1'b0;
    tick; tick; tick; st("beq.taken", C_BR_T, 1'b1);
    alu_zero = 1'b0; alu_gt = 1'b1;
    tick; tick; tick; st("beq.not", C_BR_N, 1'b1);
    opcode = 3'b011; alu_zero = 1'b1; alu_gt = 1'b0;
    tick; tick; tick; st("bgt.not", C_BR_N, 1'b1);
    alu_zero = 1'b0; alu_gt = 1'b1;
    tick; tick; tick; st("bgt.taken", C_BR_T, 1'b1);

    // jump
    opcode = 3'b110;
    tick; st("j.fetch", C_FRDY, 1'b1);
    tick; st("j.decode", C_DECODE, 1'b1);
    tick; st("j.jump", C_JUMP, 1'b1);

    // illegal opcode: back to FETCH, no retire, sticky flag
    opcode = 3'b111;
    tick; st("ill.fetch", C_FRDY, 1'b1);
    chk("ill.flag_before", {15'd0, illegal_op}, 16'd0);
    tick; st("ill.decode", C_DECODE, 1'b1);
    tick; st("ill.refetch", C_FRDY, 1'b1);
    chk("ill.flag", {15'd0, illegal_op}, 16'd1);

    // run dropped mid-lw: instruction completes, then IDLE
    opcode = 3'b101;
    tick; st("lwr.decode", C_DECODE, 1'b1);
    run = 1'b0;
    tick; st("lwr.addr", C_ADDR, 1'b1);
    tick; st("lwr.memrd", C_MEMRD, 1'b1);
    tick; st("lwr.wbmem", C_WBMEM, 1'b1);
    tick; st("lwr.idle", C_IDLE, 1'b0);
    tick; st("lwr.idle2", C_IDLE, 1'b0);
    chk("lwr.ill_sticky", {15'd0, illegal_op}, 16'd1);

    // fetch timeout after 15 wait cycles
    run = 1'b1; mem_ready = 1'b0;
    st("to.idle", C_IDLE, 1'b0);
    tick; st("to.fetch0", C_FWAIT, 1'b1);
    for (int i = 1; i < 15; i++) begin
      tick;
      st("to.wait", C_FWAIT, 1'b1);
      chk("to.err_low", {15'd0, mem_err}, 16'd0);
    end
    tick; st("to.expired", C_IDLE, 1'b0);
    chk("to.err", {15'd0, mem_err}, 16'd1);
    mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      st("to.blocked", C_IDLE, 1'b0);
    end

    // async reset mid-writeback drops reg_write immediately and clears flags
    rst_n = 1'b0;
    #1;
    chk("rst2.flags", {14'd0, illegal_op, mem_err}, 16'd0);
    tick;
    rst_n = 1'b1; opcode = 3'b000; funct = 4'h0;
    tick; st("rst2.fetch", C_FRDY, 1'b1);
    tick; st("rst2.decode", C_DECODE, 1'b1);
    tick; st("rst2.exec", C_EXR, 1'b1);
    tick; st("rst2.wb", C_WBR, 1'b1);
    #2;
    rst_n = 1'b0;
    st("rst2.async", C_IDLE, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
